// File: rtl/w_diff_accumulator.sv
// Frame accumulator for the signed subtractor's difference stream: sums LEN samples with per-step saturation.
// Define W_DIFFACC_ABS_EN to accumulate absolute differences instead of the signed sum.
module w_diff_accumulator #(
  parameter int N     = 8,
  parameter int LEN   = 16,
  parameter int ACC_W = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [N+1:0]     DIFF_IN,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    CLR,
  output logic signed [ACC_W-1:0] SUM,
  output logic                    SAT,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

  typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CW-1:0]           cnt_q;
  logic                    flag_q;
  logic signed [ACC_W-1:0] sum_q;
  logic                    sat_q;
  logic                    out_valid_q;

  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sample_val;
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W-1:0] acc_d;
  logic                    clamp_d;
  logic                    accept;

  assign sample_ext = ACC_W'(DIFF_IN);

`ifdef W_DIFFACC_ABS_EN
  // ACC_W >= N+3 here, so negating the most negative sample cannot overflow.
  assign sample_val = sample_ext[ACC_W-1] ? -sample_ext : sample_ext;
`else
  assign sample_val = sample_ext;
`endif

  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q} + {sample_val[ACC_W-1], sample_val};
    acc_d    = sum_wide[ACC_W-1:0];
    clamp_d  = 1'b0;
    // Top two bits disagree only when the result left the ACC_W range.
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      clamp_d = 1'b1;
      acc_d   = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  assign in_ready  = (state_q == ST_ACC) && !rst;
  assign accept    = in_valid && in_ready;
  assign SUM       = sum_q;
  assign SAT       = sat_q;
  assign out_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      flag_q      <= 1'b0;
      sum_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (CLR) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            flag_q <= 1'b0;
          end else if (accept) begin
            if (cnt_q == CNT_LAST) begin
              sum_q       <= acc_d;
              sat_q       <= flag_q | clamp_d;
              acc_q       <= '0;
              cnt_q       <= '0;
              flag_q      <= 1'b0;
              state_q     <= ST_HOLD;
              out_valid_q <= 1'b1;
            end else begin
              acc_q  <= acc_d;
              cnt_q  <= cnt_q + CW'(1);
              flag_q <= flag_q | clamp_d;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_q     <= ST_ACC;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_ACC;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_w_diff_accumulator.sv
// Bench for w_diff_accumulator (N=8, LEN=4, ACC_W=11): directed frames plus random traffic against a frame-level model.
module tb_w_diff_accumulator;

  localparam int N     = 8;
  localparam int LEN   = 4;
  localparam int ACC_W = 11;
  localparam int MAXV  = (1 << (ACC_W - 1)) - 1;
  localparam int MINV  = -(1 << (ACC_W - 1));

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic signed [N+1:0]     diff_in = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic                    clr = 1'b0;
  logic signed [ACC_W-1:0] sum;
  logic                    sat;
  logic                    out_valid;
  logic                    out_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: samples of the open frame, and the last completed frame result.
  int frame_q[$];
  bit m_hold = 1'b0;
  int m_sum  = 0;
  bit m_sat  = 1'b0;

  w_diff_accumulator #(.N(N), .LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .DIFF_IN   (diff_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .CLR       (clr),
    .SUM       (sum),
    .SAT       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void close_frame();
    int acc = 0;
    bit s = 1'b0;
    foreach (frame_q[i]) begin
`ifdef W_DIFFACC_ABS_EN
      acc += (frame_q[i] < 0) ? -frame_q[i] : frame_q[i];
`else
      acc += frame_q[i];
`endif
      if (acc > MAXV) begin acc = MAXV; s = 1'b1; end
      if (acc < MINV) begin acc = MINV; s = 1'b1; end
    end
    m_sum = acc;
    m_sat = s;
    frame_q.delete();
  endfunction

  task automatic step(input bit r, input bit v, input int d, input bit c, input bit o);
    rst = r; in_valid = v; diff_in = (N+2)'(d); clr = c; out_ready = o;
    @(posedge clk);
    if (r) begin
      frame_q.delete(); m_hold = 1'b0; m_sum = 0; m_sat = 1'b0;
    end else if (!m_hold) begin
      if (c) frame_q.delete();
      else if (v) begin
        frame_q.push_back(d);
        if (frame_q.size() == LEN) begin
          close_frame();
          m_hold = 1'b1;
        end
      end
    end else if (o) begin
      m_hold = 1'b0;
    end
    #1;
    chk("out_valid", int'(out_valid), int'(m_hold));
    chk("in_ready", int'(in_ready), int'(!m_hold && !r));
    chk("sum", int'(sum), m_sum);
    chk("sat", int'(sat), int'(m_sat));
  endtask

  task automatic frame4(input int a, input int b, input int c, input int d, input bit o);
    step(0, 1, a, 0, 1);
    step(0, 1, b, 0, 1);
    step(0, 1, c, 0, 1);
    step(0, 1, d, 0, o);
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 1, 7, 0, 1);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sum", int'(sum), 0);

    frame4(10, -3, 7, 100, 1);
    chk("basic_sum", int'(sum), 114);
    chk("basic_hold_rdy", int'(in_ready), 0);
    step(0, 0, 0, 0, 1);

    frame4(511, 511, 511, 511, 1);
    chk("pos_sat_sum", int'(sum), 1023);
    chk("pos_sat_flag", int'(sat), 1);
    step(0, 0, 0, 0, 1);
    frame4(1, 1, 1, 1, 1);
    chk("sat_clear_sum", int'(sum), 4);
    chk("sat_clear_flag", int'(sat), 0);
    step(0, 0, 0, 0, 1);

`ifndef W_DIFFACC_ABS_EN
    frame4(-512, -512, -512, -512, 1);
    chk("neg_sat_sum", int'(sum), -1024);
    chk("neg_sat_flag", int'(sat), 1);
    step(0, 0, 0, 0, 1);
`endif

    frame4(1, 2, 3, 4, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 9, 0, 0);
      chk("bp_sum", int'(sum), 10);
      chk("bp_rdy", int'(in_ready), 0);
    end
    step(0, 1, 9, 0, 1);
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_rdy", int'(in_ready), 1);
    step(0, 0, 0, 0, 1);

    step(0, 1, 50, 0, 1);
    step(0, 1, 60, 0, 1);
    step(0, 1, 70, 1, 1);
    frame4(1, 2, 3, 4, 1);
    chk("clr_sum", int'(sum), 10);
    step(0, 0, 0, 0, 1);

    step(0, 1, 5, 0, 1);
    step(0, 1, 5, 0, 1);
    step(1, 0, 0, 0, 1);
    frame4(1, 1, 1, 1, 0);
    chk("rst_mid_sum", int'(sum), 4);
    step(1, 0, 0, 0, 0);
    chk("rst_hold_valid", int'(out_valid), 0);
    chk("rst_hold_sum", int'(sum), 0);

    for (int i = 0; i < 3000; i++) begin
      bit r = ($urandom_range(0, 99) == 0);
      bit c = ($urandom_range(0, 19) == 0);
      bit v = ($urandom_range(0, 9) < 7);
      bit o = ($urandom_range(0, 1) == 1);
      int d;
      case ($urandom_range(0, 3))
        0:       d = 511;
        1:       d = -512;
        default: d = int'($urandom_range(0, 1023)) - 512;
      endcase
      step(r, v, d, c, o);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/w_diff_accumulator.md
Name: w_diff_accumulator

Overview:
- Stage directly downstream of the signed subtractor. Consumes its (N+2)-bit signed difference stream.
- Sums LEN consecutive accepted differences into one frame total, saturated to ACC_W bits.
- Presents each frame total on a valid/ready output with a sticky saturation flag.
- Used for frame-level error or offset measurement, e.g. sum of A−B over a block.

Parameters:
- N, 8: subtractor input width. Difference input is N+2 bits signed.
- LEN, 16: samples per frame, ≥1.
- ACC_W, 14: accumulator and SUM width, signed, ≥N+2 (≥N+3 when W_DIFFACC_ABS_EN is defined).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- DIFF_IN  input  N+2  signed difference sample from subtractor.
- in_valid  input  1  DIFF_IN valid.
- in_ready  output  1  block accepts a sample this cycle.
- CLR  input  1  synchronous discard of the partial frame.
- SUM  output  ACC_W  signed frame total.
- SAT  output  1  saturation occurred in this frame.
- out_valid  output  1  SUM/SAT valid.
- out_ready  input  1  consumer accepts SUM.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at clk edge):
  - acc=0, cnt=0, SUM=0, SAT=0, out_valid=0, state=ACC.
  - in_ready=0 while rst is high.
  - Reset mid-frame or while holding output discards everything; no output is emitted.
- States: ACC, HOLD. in_ready = (state==ACC) && !rst, combinational. out_valid is registered and equals (state==HOLD).
- Accept: in_valid && in_ready.
- ACC, accepted sample, cnt<LEN-1:
  - acc ← sat(acc + sext(DIFF_IN)); cnt++.
  - Sticky internal flag set if the clamp fired.
- ACC, accepted sample, cnt==LEN-1:
  - SUM ← sat(acc + sext(DIFF_IN)); SAT ← flag | clamp-this-cycle.
  - acc ← 0, cnt ← 0, flag ← 0; state ← HOLD.
  - out_valid rises the cycle after the last sample is accepted (latency 1).
- HOLD:
  - in_ready=0; SUM/SAT held stable.
  - On out_ready=1: state ← ACC, out_valid=0 next cycle. One-cycle bubble: the first sample of the next frame is accepted no earlier than the cycle after the handshake.
- Saturation:
  - Add at ACC_W+1 bits.
  - Clamp to [−2^(ACC_W−1), 2^(ACC_W−1)−1] on every step, not only at frame end.
- CLR in ACC:
  - acc, cnt, flag ← 0.
  - CLR with a simultaneous accept: CLR wins, sample dropped (in_ready still shows 1; the source treats it as consumed).
- CLR in HOLD: no effect on SUM, SAT or out_valid.
- LEN=1: every accepted sample produces an output. SUM=sext(DIFF_IN) unless clamped.
- in_valid with in_ready=0: sample not consumed. The source must hold it.

Optional Feature:
- Macro: W_DIFFACC_ABS_EN.
- Defined:
  - Each sample's absolute value is accumulated (sum of absolute differences), computed after sign-extension to ACC_W so that −2^(N+1) maps to +2^(N+1) without overflow.
  - acc and SUM are then never negative. Saturation applies only at the positive bound.
- Undefined: signed sum as above; no abs logic synthesized.

Test Plan:
- Config N=8, LEN=4, ACC_W=11 unless noted.
- Basic frame: rst 2 cycles, then DIFF_IN 10,−3,7,100 with in_valid=1 and out_ready=1 → out_valid=1 one cycle after the 4th accept, SUM=114, SAT=0. in_ready=0 in the HOLD cycle.
- Positive saturation: 4×511 → SUM=1023, SAT=1. Next frame 1,1,1,1 → SUM=4, SAT=0 (flag cleared).
- Negative saturation / abs: 4×−512 → SUM=−1024, SAT=1. With W_DIFFACC_ABS_EN and ACC_W=12 → SUM=2047, SAT=1. With W_DIFFACC_ABS_EN, ACC_W=12 and inputs −5,5,−5,5 → SUM=20.
- Backpressure: frame 1,2,3,4 with out_ready=0 for 5 cycles → SUM=10 stable, out_valid=1, in_ready=0 throughout. Raise out_ready for 1 cycle → out_valid=0 next cycle, then in_ready=1.
- CLR: accept 50,60, then CLR together with in_valid=1 and DIFF_IN=70, then 1,2,3,4 → SUM=10 (50, 60, 70 discarded).
- Reset mid-frame: accept 5,5 then rst 1 cycle, then 1,1,1,1 → single output SUM=4. Separately, rst during HOLD → out_valid=0 and SUM=0 next cycle.
